pc_unit: RTL and testbench

Parametrised program-counter unit for the next-generation (pipelined) CPU datapath. It holds the fetch PC and selects the next PC from these sources:
- sequential increment
- branch/jump redirect
- exception entry
- exception return

It adds stall handling, a pending-redirect buffer for redirects that arrive while stalled, EPC capture, and misalignment flagging. It sits at the head of the fetch stage and drives the instruction-memory address.

---
 rtl/pc_unit.sv | 94 +++++++++
 tb/tb_pc_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_unit : fetch program counter with stall, deferred redirect, EPC capture
// Rev 1.0
// ---------------------------------------------------------------------------
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_4180),
  parameter int               STEP         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic [WIDTH-1:0] epc,
  output logic             pending,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam int               ALIGN_BITS = $clog2(STEP);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic             pending_q, pending_d;
  logic [WIDTH-1:0] pc_inc;

  assign pc_inc = pc_q + STEP_W;

  always_comb begin
    pc_d          = pc_q;
    epc_d         = epc_q;
    pending_d     = pending_q;
    pend_target_d = pend_target_q;
    if (exc_req) begin
      pc_d      = EXC_VECTOR;
      epc_d     = pc_q;
      pending_d = 1'b0;
    end else if (eret) begin
      pc_d      = epc_q;
      pending_d = 1'b0;
    end else if (stall) begin
      // Redirects seen while stalled are parked; the newest one wins.
      if (br_valid) begin
        pend_target_d = br_target;
        pending_d     = 1'b1;
      end
    end else if (br_valid) begin
      pc_d      = br_target;
      pending_d = 1'b0;
    end else if (pending_q) begin
      pc_d      = pend_target_q;
      pending_d = 1'b0;
    end else begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_VECTOR;
      epc_q         <= '0;
      pending_q     <= 1'b0;
      pend_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      pending_q     <= pending_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc          = pc_q;
  assign pc_next_seq = pc_inc;
  assign epc         = epc_q;
  assign pending     = pending_q;

  generate
    if (ALIGN_BITS == 0) begin : g_no_align
      assign misalign = 1'b0;
    end else begin : g_align
      assign misalign = |pc_q[ALIGN_BITS-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pc_unit : directed plus randomized checks of pc_unit against a model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, br_valid, exc_req, eret;
  logic [31:0] br_target;
  logic [31:0] pc, pc_next_seq, epc;
  logic        pending, misalign;

  int n_cmp = 0;
  int n_err = 0;

  // reference state
  logic [31:0] m_pc, m_epc, m_tgt;
  logic        m_pend;

  pc_unit #(
    .WIDTH       (32),
    .RESET_VECTOR(32'h0000_3000),
    .EXC_VECTOR  (32'h0000_4180),
    .STEP        (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .exc_req    (exc_req),
    .eret       (eret),
    .pc         (pc),
    .pc_next_seq(pc_next_seq),
    .epc        (epc),
    .pending    (pending),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Next state from the priority rules, applied to the inputs currently driven.
  task automatic model_step();
    if (reset) begin
      m_pc = 32'h3000; m_epc = 0; m_pend = 0; m_tgt = 0;
    end else if (exc_req) begin
      m_epc = m_pc; m_pc = 32'h4180; m_pend = 0;
    end else if (eret) begin
      m_pc = m_epc; m_pend = 0;
    end else if (stall) begin
      if (br_valid) begin m_tgt = br_target; m_pend = 1; end
    end else if (br_valid) begin
      m_pc = br_target; m_pend = 0;
    end else if (m_pend) begin
      m_pc = m_tgt; m_pend = 0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},   pc, m_pc);
    check({tag, ".seq"},  pc_next_seq, m_pc + 32'd4);
    check({tag, ".epc"},  epc, m_epc);
    check({tag, ".pend"}, {31'b0, pending}, {31'b0, m_pend});
    check({tag, ".mis"},  {31'b0, misalign}, {31'b0, (m_pc % 4) != 0});
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic idle();
    reset = 0; stall = 0; br_valid = 0; br_target = 0; exc_req = 0; eret = 0;
  endtask

  initial begin
    m_pc = 'x; m_epc = 'x; m_tgt = 'x; m_pend = 1'bx;
    idle();
    @(posedge clk); #1;

    // 1: reset then free run, mid-run reset
    reset = 1; cycle("rst");
    check("t1_pc0", pc, 32'h3000);
    check("t1_epc0", epc, 32'h0);
    reset = 0;
    cycle("run1"); check("t1_pc1", pc, 32'h3004);
    cycle("run2"); check("t1_pc2", pc, 32'h3008);
    cycle("run3"); check("t1_pc3", pc, 32'h300C);
    check("t1_seq3", pc_next_seq, 32'h3010);
    reset = 1; cycle("rst2"); check("t1_rst", pc, 32'h3000);
    reset = 0;

    // 2: redirect during stall is deferred
    cycle("a"); cycle("b"); check("t2_pc", pc, 32'h3008);
    stall = 1; br_valid = 1; br_target = 32'h3100; cycle("st1");
    check("t2_hold1", pc, 32'h3008); check("t2_pend1", {31'b0, pending}, 32'd1);
    br_valid = 0; cycle("st2");
    check("t2_hold2", pc, 32'h3008); check("t2_pend2", {31'b0, pending}, 32'd1);
    stall = 0; cycle("rel"); check("t2_rel", pc, 32'h3100);
    check("t2_pend0", {31'b0, pending}, 32'd0);
    cycle("seq"); check("t2_seq", pc, 32'h3104);

    // 3: live redirect beats buffered one; newer buffered overwrites older
    stall = 1; br_valid = 1; br_target = 32'h3100; cycle("s3a");
    stall = 0; br_target = 32'h3200; cycle("r3a"); check("t3_live", pc, 32'h3200);
    check("t3_pend", {31'b0, pending}, 32'd0);
    stall = 1; br_target = 32'h3100; cycle("s3b");
    br_target = 32'h3300; cycle("s3c");
    stall = 0; br_valid = 0; cycle("r3b"); check("t3_over", pc, 32'h3300);

    // 4: exception entry and return
    br_valid = 1; br_target = 32'h3010; cycle("to3010");
    stall = 1; br_target = 32'h3100; cycle("s4");
    br_valid = 0; exc_req = 1; cycle("exc");
    check("t4_pc", pc, 32'h4180); check("t4_epc", epc, 32'h3010);
    check("t4_pend", {31'b0, pending}, 32'd0);
    stall = 0; exc_req = 0; cycle("e1"); cycle("e2");
    eret = 1; cycle("eret"); check("t4_eret", pc, 32'h3010);
    check("t4_epc2", epc, 32'h3010);
    eret = 0; exc_req = 1; cycle("exc2"); exc_req = 0; cycle("x");
    check("t4_pre", pc, 32'h4184);
    exc_req = 1; eret = 1; cycle("both");
    check("t4_both", pc, 32'h4180); check("t4_bepc", epc, 32'h4184);
    exc_req = 0; eret = 0;

    // 5: misaligned target and wrap
    br_valid = 1; br_target = 32'h3102; cycle("mis");
    check("t5_pc", pc, 32'h3102); check("t5_mis", {31'b0, misalign}, 32'd1);
    br_valid = 0; cycle("mis2"); check("t5_next", pc, 32'h3106);
    br_valid = 1; br_target = 32'hFFFF_FFFC; cycle("top");
    check("t5_seqwrap", pc_next_seq, 32'h0);
    br_valid = 0; cycle("wrap"); check("t5_wrap", pc, 32'h0);
    check("t5_mis0", {31'b0, misalign}, 32'd0);

    // 6: reset overrides everything; eret with cleared epc goes to 0
    stall = 1; br_valid = 1; br_target = 32'h5000; cycle("pend6");
    reset = 1; exc_req = 1; stall = 0; cycle("rst6");
    check("t6_pc", pc, 32'h3000); check("t6_epc", epc, 32'h0);
    check("t6_pend", {31'b0, pending}, 32'd0);
    idle(); eret = 1; cycle("eret0"); check("t6_eret0", pc, 32'h0);
    idle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 49) == 0);
      stall     = ($urandom_range(0, 9) < 4);
      br_valid  = ($urandom_range(0, 9) < 3);
      br_target = ($urandom_range(0, 7) == 0) ? $urandom : {$urandom_range(0, 32'hFFFF), 2'b00};
      exc_req   = ($urandom_range(0, 24) == 0);
      eret      = ($urandom_range(0, 24) == 0);
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
